// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Default 640x480 VGA timing constants, sync bundle type and helpers.
// Revision : 1.0
// ============================================================================
package vga_timing_pkg;

  localparam int c_CNT_W = 10;
  localparam int c_RGB_W = 12;

  localparam int c_H_DISP  = 640;
  localparam int c_H_FP    = 16;
  localparam int c_H_SYNC  = 96;
  localparam int c_H_BP    = 48;
  localparam int c_H_TOTAL = c_H_DISP + c_H_FP + c_H_SYNC + c_H_BP;

  localparam int c_V_DISP  = 480;
  localparam int c_V_FP    = 10;
  localparam int c_V_SYNC  = 2;
  localparam int c_V_BP    = 33;
  localparam int c_V_TOTAL = c_V_DISP + c_V_FP + c_V_SYNC + c_V_BP;

  localparam logic c_SYNC_ACTIVE = 1'b0;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
  } sync_t;

  localparam int    c_SYNC_W    = $bits(sync_t);
  localparam sync_t c_SYNC_IDLE = '{hs: ~c_SYNC_ACTIVE, vs: ~c_SYNC_ACTIVE, vis: 1'b0};

  function automatic logic in_window(input logic [c_CNT_W-1:0] val,
                                     input logic [c_CNT_W-1:0] lo,
                                     input logic [c_CNT_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_if
// Brief    : Counter/pixel/pin bundle between the timing engine and its users.
// Revision : 1.0
// ============================================================================
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic [c_RGB_W-1:0] pixel_in;
  logic [c_CNT_W-1:0] h_cnt;
  logic [c_CNT_W-1:0] v_cnt;
  logic               hsync;
  logic               vsync;
  logic               valid;
  logic [3:0]         vgaRed;
  logic [3:0]         vgaGreen;
  logic [3:0]         vgaBlue;
  logic               frame_start;

  modport master (
    input  pixel_in,
    output h_cnt, v_cnt, hsync, vsync, valid,
    output vgaRed, vgaGreen, vgaBlue, frame_start
  );

  modport slave (
    output pixel_in,
    input  h_cnt, v_cnt, hsync, vsync, valid,
    input  vgaRed, vgaGreen, vgaBlue, frame_start
  );

endinterface
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_delay
// Brief    : WIDTH x DEPTH shift register with a caller-supplied reset value.
// Revision : 1.0
// ============================================================================
module vga_sync_delay #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rst_val_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= rst_val_i;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Pixel-tick divider, h/v counters, sync/blank alignment, RGB pins.
// Revision : 1.0
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISP  = c_H_DISP,
  parameter int H_FP    = c_H_FP,
  parameter int H_SYNC  = c_H_SYNC,
  parameter int H_BP    = c_H_BP,
  parameter int V_DISP  = c_V_DISP,
  parameter int V_FP    = c_V_FP,
  parameter int V_SYNC  = c_V_SYNC,
  parameter int V_BP    = c_V_BP,
  parameter int CLK_DIV = 4,
  parameter int PIPE    = 1
) (
  input  logic               clk,
  input  logic               rst,
  vga_timing_gen_if.master   vga
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [c_CNT_W-1:0] H_LAST   = c_CNT_W'(H_TOTAL - 1);
  localparam logic [c_CNT_W-1:0] V_LAST   = c_CNT_W'(V_TOTAL - 1);
  localparam logic [c_CNT_W-1:0] H_VIS    = c_CNT_W'(H_DISP);
  localparam logic [c_CNT_W-1:0] V_VIS    = c_CNT_W'(V_DISP);
  localparam logic [c_CNT_W-1:0] HS_FIRST = c_CNT_W'(H_DISP + H_FP);
  localparam logic [c_CNT_W-1:0] HS_LAST  = c_CNT_W'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [c_CNT_W-1:0] VS_FIRST = c_CNT_W'(V_DISP + V_FP);
  localparam logic [c_CNT_W-1:0] VS_LAST  = c_CNT_W'(V_DISP + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [c_CNT_W-1:0] h_q, h_d;
  logic [c_CNT_W-1:0] v_q, v_d;
  logic               fs_q, fs_d;
  logic [c_RGB_W-1:0] rgb_q, rgb_d;
  logic               w_tick;
  sync_t              w_sync_raw;
  sync_t              w_sync_dly;

  always_comb begin
    w_tick = (div_q == DIV_LAST);
    div_d  = w_tick ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    fs_d   = 1'b0;
    if (w_tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d  = '0;
          // Registered so the pulse lands on the first cycle showing (0,0).
          fs_d = 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end

    w_sync_raw.hs  = in_window(h_q, HS_FIRST, HS_LAST) ? c_SYNC_ACTIVE : ~c_SYNC_ACTIVE;
    w_sync_raw.vs  = in_window(v_q, VS_FIRST, VS_LAST) ? c_SYNC_ACTIVE : ~c_SYNC_ACTIVE;
    w_sync_raw.vis = (h_q < H_VIS) && (v_q < V_VIS);

    // pixel_in arrives PIPE clk late, so it lines up with the delayed vis.
    rgb_d = w_sync_dly.vis ? vga.pixel_in : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      fs_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      fs_q  <= fs_d;
      rgb_q <= rgb_d;
    end
  end

  vga_sync_delay #(
    .WIDTH (c_SYNC_W),
    .DEPTH (PIPE)
  ) u_sync_delay (
    .clk       (clk),
    .rst       (rst),
    .rst_val_i (c_SYNC_IDLE),
    .d_i       (w_sync_raw),
    .q_o       (w_sync_dly)
  );

  assign vga.h_cnt       = h_q;
  assign vga.v_cnt       = v_q;
  assign vga.hsync       = w_sync_dly.hs;
  assign vga.vsync       = w_sync_dly.vs;
  assign vga.valid       = w_sync_dly.vis;
  assign vga.vgaRed      = rgb_q[11:8];
  assign vga.vgaGreen    = rgb_q[7:4];
  assign vga.vgaBlue     = rgb_q[3:0];
  assign vga.frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Randomized-pixel bench for vga_timing_gen on a shrunken raster.
// Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;

  localparam int H_DISP  = 8;
  localparam int H_FP    = 2;
  localparam int H_SYNC  = 3;
  localparam int H_BP    = 2;
  localparam int V_DISP  = 4;
  localparam int V_FP    = 1;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 1;
  localparam int CLK_DIV = 4;
  localparam int PIPE    = 2;
  localparam int HT      = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int VT      = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int LINE    = HT * CLK_DIV;
  localparam int FRAME   = LINE * VT;
  localparam int HIST    = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .H_DISP (H_DISP), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_DISP (V_DISP), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .CLK_DIV (CLK_DIV), .PIPE (PIPE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vga (vif)
  );

  always #5 clk = ~clk;

  int          n;
  int          total = 0;
  int          bad   = 0;
  int          fs_cnt;
  int          hs_low_cnt;
  int          vis_cnt;
  bit          const_mode = 1'b0;
  logic [11:0] ph [HIST];

  // Clock edges seen since reset release; the model is a pure function of it.
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  function automatic int h_at(input int k);
    return (k / CLK_DIV) % HT;
  endfunction

  function automatic int v_at(input int k);
    return ((k / CLK_DIV) / HT) % VT;
  endfunction

  // {hsync, vsync, vis} implied by the raster position after k edges.
  function automatic logic [2:0] raw_at(input int k);
    int  h, v;
    logic hs, vs, vis;
    if (k < 0) return 3'b110;
    h   = h_at(k);
    v   = v_at(k);
    hs  = !(h >= H_DISP + H_FP && h < H_DISP + H_FP + H_SYNC);
    vs  = !(v >= V_DISP + V_FP && v < V_DISP + V_FP + V_SYNC);
    vis = (h < H_DISP) && (v < V_DISP);
    return {hs, vs, vis};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: n=%0d got=%0h want=%0h", name, n, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [2:0]  r;
    logic [2:0]  rp;
    logic [11:0] rgb_e;
    if (rst) begin
      fs_cnt     <= 0;
      hs_low_cnt <= 0;
      vis_cnt    <= 0;
    end else begin
      r     = raw_at(n - PIPE);
      rp    = raw_at(n - 1 - PIPE);
      rgb_e = 12'h000;
      if (n >= 1 && n - 1 < HIST && rp[0]) rgb_e = ph[n-1];
      check("h_cnt", int'(vif.h_cnt), h_at(n));
      check("v_cnt", int'(vif.v_cnt), v_at(n));
      check("hsync", int'(vif.hsync), int'(r[2]));
      check("vsync", int'(vif.vsync), int'(r[1]));
      check("valid", int'(vif.valid), int'(r[0]));
      check("rgb", int'({vif.vgaRed, vif.vgaGreen, vif.vgaBlue}), int'(rgb_e));
      check("frame_start", int'(vif.frame_start), int'(n > 0 && n % FRAME == 0));
      if (n == CLK_DIV - 1) check("pin_h_before_tick", int'(vif.h_cnt), 0);
      if (n == CLK_DIV)     check("pin_first_tick", int'(vif.h_cnt), 1);
      if (n == FRAME - 1)   check("pin_last_pos", int'({vif.v_cnt, vif.h_cnt}), (7 << 10) | 14);
      if (n == FRAME) begin
        check("pin_fs_at_wrap", int'(vif.frame_start), 1);
        check("pin_pos_after_wrap", int'({vif.v_cnt, vif.h_cnt}), 0);
        check("pin_v_after_h_wrap", int'(vif.v_cnt), 0);
      end
      if (n == LINE) check("pin_line_wrap", int'({vif.v_cnt, vif.h_cnt}), (1 << 10));
      if (n == 41)   check("pin_hs_before_fall", int'(vif.hsync), 1);
      if (n == 42)   check("pin_hs_fall", int'(vif.hsync), 0);
      if (n == 54)   check("pin_hs_rise", int'(vif.hsync), 1);
      if (vif.frame_start) fs_cnt <= fs_cnt + 1;
      if (n <= LINE && !vif.hsync) hs_low_cnt <= hs_low_cnt + 1;
      if (n <= LINE && vif.valid)  vis_cnt <= vis_cnt + 1;
    end
  end

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      vif.pixel_in = const_mode ? 12'hABC : 12'($urandom);
      if (n < HIST) ph[n] = vif.pixel_in;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_h"}, int'(vif.h_cnt), 0);
    check({tag, "_v"}, int'(vif.v_cnt), 0);
    check({tag, "_hsync"}, int'(vif.hsync), 1);
    check({tag, "_vsync"}, int'(vif.vsync), 1);
    check({tag, "_valid"}, int'(vif.valid), 0);
    check({tag, "_rgb"}, int'({vif.vgaRed, vif.vgaGreen, vif.vgaBlue}), 0);
    check({tag, "_fs"}, int'(vif.frame_start), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    vif.pixel_in = 12'h000;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1 rst = 1'b0;

    // Two full frames plus a little, random pixels.
    run(2 * FRAME + 40);
    check("frame_start_pulses", fs_cnt, 2);
    check("hs_low_line0", hs_low_cnt, H_SYNC * CLK_DIV);
    check("valid_line0", vis_cnt, H_DISP * CLK_DIV);

    // Constant colour, then an asynchronous reset mid-frame.
    const_mode = 1'b1;
    guard = 0;
    while (!(vif.h_cnt == 10'd5 && vif.v_cnt == 10'd2) && guard < 2 * FRAME) begin
      run(1);
      guard++;
    end
    check("reach_reset_point", int'(guard < 2 * FRAME), 1);
    run(2);
    check("pre_reset_h", int'(vif.h_cnt), 5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b0;

    // Restart from (0,0) with random pixels; only the wrap may pulse.
    const_mode = 1'b0;
    run(FRAME + 300);
    check("frame_start_after_rst", fs_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
